// File: rtl/cpu_types_pkg.sv
// Shared types for the memory responder slice.
//   word_t           : 32-bit bus word
//   ramstate_t       : RAM handshake state (FREE/BUSY/ACCESS/ERROR)
//   memresp_state_t  : responder FSM states
//   ABORT_WORD       : load value returned when a transaction is aborted
package cpu_types_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    RESP_I = 3'd3,
    RESP_D = 3'd4
  } memresp_state_t;

  localparam word_t ABORT_WORD = 32'hBAD0BAD0;

  // Response state that follows a busy state.
  function automatic memresp_state_t resp_of(input memresp_state_t s);
    return (s == BUSY_D) ? RESP_D : RESP_I;
  endfunction
endpackage

// File: rtl/mem_responder_if.sv
// Request/RAM bus bundle for mem_responder.
//   CPU side : iREN/iaddr/iwait/iload, dREN/dWEN/daddr/dstore/dwait/dload
//   RAM side : ramREN/ramWEN/ramaddr/ramstore/ramload/ramstate, ram_err
// Modports: slave = the responder, master = requester + RAM environment.
interface mem_responder_if;
  import cpu_types_pkg::*;

  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dwait;
  word_t     dload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
  logic      ram_err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ram_err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ram_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Next-grant logic for the single RAM port plus the data-starvation counter.
// Ports:
//   i_clk, i_nrst : clock, synchronous active-low reset
//   i_arb_en      : responder is idle and may grant this cycle
//   i_dreq        : data read or write pending
//   i_ireq        : instruction fetch pending
//   o_grant_d/i   : one-hot grant (combinational, valid only with i_arb_en)
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic i_clk,
  input  logic i_nrst,
  input  logic i_arb_en,
  input  logic i_dreq,
  input  logic i_ireq,
  output logic o_grant_d,
  output logic o_grant_i
);
  localparam int            CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] r_starve_cnt;
  logic          w_starved;

  // The limit only bites while a fetch is actually waiting; with iREN low a
  // saturated count must not lock out data forever.
  assign w_starved = i_ireq && (r_starve_cnt >= LIMIT);
  assign o_grant_d = i_arb_en && i_dreq && !w_starved;
  assign o_grant_i = i_arb_en && i_ireq && !o_grant_d;

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      r_starve_cnt <= '0;
    end else if (o_grant_d) begin
      if (!i_ireq)                r_starve_cnt <= '0;
      else if (r_starve_cnt < LIMIT) r_starve_cnt <= r_starve_cnt + 1'b1;
    end else if (o_grant_i) begin
      r_starve_cnt <= '0;
    end
  end
endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: arbitrates instruction and data requests onto one
// RAM port, holds the requester in wait until RAM completes, then releases
// wait for exactly one cycle with the load data.
// Ports:
//   CLK, nRST : clock, synchronous active-low reset
//   bus       : mem_responder_if.slave (CPU request channels + RAM port)
//   stat_*    : only with MEM_RESP_STATS_EN defined -- completed instruction
//               and data transactions, and cycles spent in BUSY_I/BUSY_D
// Optional feature macro: MEM_RESP_STATS_EN
module mem_responder
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_RETRY    = 3
) (
  input  logic           CLK,
  input  logic           nRST,
  mem_responder_if.slave bus
`ifdef MEM_RESP_STATS_EN
  ,
  output word_t          stat_icount,
  output word_t          stat_dcount,
  output word_t          stat_stall
`endif
);
  localparam int            RW         = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);

  memresp_state_t r_state;
  logic           r_wr;
  word_t          r_addr;
  word_t          r_store;
  logic           r_ramREN;
  logic           r_ramWEN;
  logic           r_ram_err;
  word_t          r_iload;
  word_t          r_dload;
  logic [RW-1:0]  r_retry_cnt;

  logic w_arb_en, w_grant_d, w_grant_i;

  assign w_arb_en = (r_state == IDLE);

  mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) u_arb (
    .i_clk    (CLK),
    .i_nrst   (nRST),
    .i_arb_en (w_arb_en),
    .i_dreq   (bus.dREN | bus.dWEN),
    .i_ireq   (bus.iREN),
    .o_grant_d(w_grant_d),
    .o_grant_i(w_grant_i)
  );

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state     <= IDLE;
      r_wr        <= 1'b0;
      r_addr      <= '0;
      r_store     <= '0;
      r_ramREN    <= 1'b0;
      r_ramWEN    <= 1'b0;
      r_ram_err   <= 1'b0;
      r_iload     <= '0;
      r_dload     <= '0;
      r_retry_cnt <= '0;
    end else begin
      r_ram_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            // dWEN wins when both strobes are high
            r_wr        <= bus.dWEN;
            r_addr      <= bus.daddr;
            r_store     <= bus.dstore;
            r_ramREN    <= !bus.dWEN;
            r_ramWEN    <= bus.dWEN;
            r_retry_cnt <= '0;
            r_state     <= BUSY_D;
          end else if (w_grant_i) begin
            r_wr        <= 1'b0;
            r_addr      <= bus.iaddr;
            r_store     <= '0;
            r_ramREN    <= 1'b1;
            r_ramWEN    <= 1'b0;
            r_retry_cnt <= '0;
            r_state     <= BUSY_I;
          end
        end
        BUSY_I, BUSY_D: begin
          case (bus.ramstate)
            ACCESS: begin
              r_ramREN    <= 1'b0;
              r_ramWEN    <= 1'b0;
              r_retry_cnt <= '0;
              if (r_state == BUSY_I)  r_iload <= bus.ramload;
              else if (!r_wr)         r_dload <= bus.ramload;
              r_state <= resp_of(r_state);
            end
            ERROR: begin
              // strobes stay up on a retry so the RAM sees the access again
              if (r_retry_cnt == RETRY_LAST) begin
                r_ramREN    <= 1'b0;
                r_ramWEN    <= 1'b0;
                r_retry_cnt <= '0;
                r_ram_err   <= 1'b1;
                if (r_state == BUSY_I) r_iload <= ABORT_WORD;
                else                   r_dload <= ABORT_WORD;
                r_state <= resp_of(r_state);
              end else begin
                r_retry_cnt <= r_retry_cnt + 1'b1;
              end
            end
            default: ;
          endcase
        end
        RESP_I, RESP_D: r_state <= IDLE;
        default:        r_state <= IDLE;
      endcase
    end
  end

  assign bus.ramREN   = r_ramREN;
  assign bus.ramWEN   = r_ramWEN;
  assign bus.ramaddr  = r_addr;
  assign bus.ramstore = r_store;
  assign bus.ram_err  = r_ram_err;
  assign bus.iload    = r_iload;
  assign bus.dload    = r_dload;
  assign bus.iwait    = (r_state != RESP_I);
  assign bus.dwait    = (r_state != RESP_D);

`ifdef MEM_RESP_STATS_EN
  word_t r_stat_icount, r_stat_dcount, r_stat_stall;

  // A transaction counts as complete during its single response cycle.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_stat_icount <= '0;
      r_stat_dcount <= '0;
      r_stat_stall  <= '0;
    end else begin
      if (r_state == RESP_I) r_stat_icount <= r_stat_icount + 32'd1;
      if (r_state == RESP_D) r_stat_dcount <= r_stat_dcount + 32'd1;
      if (r_state == BUSY_I || r_state == BUSY_D) r_stat_stall <= r_stat_stall + 32'd1;
    end
  end

  assign stat_icount = r_stat_icount;
  assign stat_dcount = r_stat_dcount;
  assign stat_stall  = r_stat_stall;
`endif
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder. Each test pushes the transactions it
// expects (in grant order) onto a queue; a negedge process plays the RAM
// from a per-transaction ramstate script and checks every busy/response/idle
// cycle against that transaction-level expectation.
module tb_mem_responder;
  import cpu_types_pkg::*;

  localparam int SL = 4;
  localparam int MR = 3;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  mem_responder_if bus();
`ifdef MEM_RESP_STATS_EN
  word_t stat_icount, stat_dcount, stat_stall;
`endif

  mem_responder #(.STARVE_LIMIT(SL), .MAX_RETRY(MR)) dut (
    .CLK (clk),
    .nRST(nrst),
    .bus (bus)
`ifdef MEM_RESP_STATS_EN
    ,
    .stat_icount(stat_icount),
    .stat_dcount(stat_dcount),
    .stat_stall (stat_stall)
`endif
  );

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {
    bit    is_d;
    bit    wr;
    word_t addr;
    word_t store;
    int    nbusy;
    bit    abort;
  } txn_t;

  txn_t      exp_q[$];
  ramstate_t script[$];   // RAM answer per busy cycle; ACCESS once exhausted

  function automatic word_t memword(input word_t a);
    if (a == 32'h40) return 32'h8C010004;
    return (a * 32'h9E3779B1) ^ 32'h0F0F1234;
  endfunction

  // Busy length / abort follow from the script: done at the first ACCESS,
  // aborted at the MR-th ERROR.
  function automatic txn_t mk(input bit is_d, input bit wr, input word_t a, input word_t s);
    txn_t t;
    int errs;
    ramstate_t rs;
    t.is_d = is_d; t.wr = wr; t.addr = a; t.store = s; t.nbusy = 0; t.abort = 0;
    errs = 0;
    for (int k = 0; k < 64; k++) begin
      rs = (k < script.size()) ? script[k] : ACCESS;
      if (rs == ACCESS) begin t.nbusy = k + 1; return t; end
      if (rs == ERROR) begin
        errs++;
        if (errs == MR) begin t.nbusy = k + 1; t.abort = 1; return t; end
      end
    end
    return t;
  endfunction

  // ---------------- RAM + compare ----------------
  txn_t  cur;
  bit    in_txn = 0, last_resp = 0;
  int    bcnt = 0, err_pulses = 0, done_cnt = 0;
  word_t m_iload = 0, m_dload = 0, exp_load;

  always @(negedge clk) begin
    if (!nrst) begin
      chk("rst_ramREN", bus.ramREN, 0);
      chk("rst_ramWEN", bus.ramWEN, 0);
      chk("rst_ram_err", bus.ram_err, 0);
      chk("rst_iwait", bus.iwait, 1);
      chk("rst_dwait", bus.dwait, 1);
      chk("rst_iload", bus.iload, 0);
      chk("rst_dload", bus.dload, 0);
      in_txn = 0; last_resp = 0; bcnt = 0; m_iload = 0; m_dload = 0;
      exp_q.delete();
      bus.ramstate = FREE; bus.ramload = 32'h0;
    end else if (bus.ramREN || bus.ramWEN) begin
      if (!in_txn) begin
        chk("grant_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) cur = exp_q.pop_front();
        else cur = '{is_d:0, wr:0, addr:0, store:0, nbusy:-1, abort:0};
        chk("idle_gap", last_resp, 0);
        in_txn = 1; bcnt = 0;
      end
      bcnt++;
      chk("ramREN", bus.ramREN, !cur.wr);
      chk("ramWEN", bus.ramWEN, cur.wr);
      chk("ramaddr", bus.ramaddr, cur.addr);
      if (cur.wr) chk("ramstore", bus.ramstore, cur.store);
      chk("busy_iwait", bus.iwait, 1);
      chk("busy_dwait", bus.dwait, 1);
      chk("busy_ram_err", bus.ram_err, 0);
      bus.ramstate = (bcnt - 1 < script.size()) ? script[bcnt-1] : ACCESS;
      bus.ramload  = cur.wr ? 32'h5555AAAA : memword(bus.ramaddr);
      last_resp = 0;
    end else if (!bus.iwait || !bus.dwait) begin
      chk("resp_in_txn", in_txn, 1);
      chk("resp_busy_cycles", bcnt, cur.nbusy);
      chk("resp_iwait", bus.iwait, cur.is_d);
      chk("resp_dwait", bus.dwait, !cur.is_d);
      chk("resp_ram_err", bus.ram_err, cur.abort);
      exp_load = cur.abort ? ABORT_WORD : (cur.wr ? m_dload : memword(cur.addr));
      if (cur.is_d) m_dload = exp_load; else m_iload = exp_load;
      chk("resp_iload", bus.iload, m_iload);
      chk("resp_dload", bus.dload, m_dload);
      if (bus.ram_err) err_pulses++;
      in_txn = 0; last_resp = 1; done_cnt++;
      bus.ramstate = FREE;
    end else begin
      chk("idle_in_txn", in_txn, 0);
      chk("idle_ram_err", bus.ram_err, 0);
      chk("idle_iload", bus.iload, m_iload);
      chk("idle_dload", bus.dload, m_dload);
      last_resp = 0;
      bus.ramstate = FREE;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Runs until n more completions. With hold, requests stay up and the
  // address steps by 4 after each completion; all requests drop at the end.
  task automatic run_txns(input int n, input int budget, input bit hold);
    int tgt, c;
    tgt = done_cnt + n;
    c = 0;
    while (done_cnt < tgt && c < budget) begin
      tick(); c++;
      if (!bus.dwait) begin
        if (hold) bus.daddr = bus.daddr + 32'd4;
        else begin bus.dREN = 0; bus.dWEN = 0; end
      end
      if (!bus.iwait) begin
        if (hold) bus.iaddr = bus.iaddr + 32'd4;
        else bus.iREN = 0;
      end
      if (done_cnt == tgt) begin bus.iREN = 0; bus.dREN = 0; bus.dWEN = 0; end
    end
    nchk++;
    if (done_cnt < tgt) begin
      nerr++;
      $display("FAIL run_txns timeout: done %0d want %0d", done_cnt, tgt);
    end
  endtask

  int lat, ren_cycles, e0;

  initial begin
    bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0;
    bus.daddr = 0; bus.dstore = 0;
    repeat (3) tick();
    chk("reset_iwait", bus.iwait, 1);
    chk("reset_dload", bus.dload, 0);
    nrst = 1;
    tick();

    // T1: single fetch, ACCESS on 2nd busy cycle
    script = '{BUSY, ACCESS};
    exp_q.push_back(mk(0, 0, 32'h40, 0));
    bus.iREN = 1; bus.iaddr = 32'h40;
    lat = 0; ren_cycles = 0;
    do begin
      tick(); lat++;
      if (bus.ramREN) ren_cycles++;
    end while (bus.iwait && lat < 20);
    chk("t1_latency", lat, 3);
    chk("t1_iload", bus.iload, 32'h8C010004);
    chk("t1_ramREN_cycles", ren_cycles, 2);
    chk("t1_ramREN_resp", bus.ramREN, 0);
    bus.iREN = 0;
    tick();
    chk("t1_iwait_one_cycle", bus.iwait, 1);
    tick();

    // T2: write and fetch together; data first, then instruction
    script = '{BUSY, ACCESS};
    exp_q.push_back(mk(1, 1, 32'h100, 32'hDEADBEEF));
    exp_q.push_back(mk(0, 0, 32'h44, 0));
    bus.dWEN = 1; bus.daddr = 32'h100; bus.dstore = 32'hDEADBEEF;
    bus.iREN = 1; bus.iaddr = 32'h44;
    tick();
    chk("t2_ramWEN", bus.ramWEN, 1);
    chk("t2_ramREN", bus.ramREN, 0);
    chk("t2_ramaddr", bus.ramaddr, 32'h100);
    chk("t2_ramstore", bus.ramstore, 32'hDEADBEEF);
    run_txns(2, 40, 0);
    chk("t2_dload_kept", bus.dload, 32'h0);
    tick(); tick();

    // T3: both held; 4 data grants, 1 fetch, 4 data, 1 fetch
    script = '{BUSY, ACCESS};
    for (int k = 0; k < 4; k++) exp_q.push_back(mk(1, 0, 32'h200 + 4*k, 0));
    exp_q.push_back(mk(0, 0, 32'h48, 0));
    for (int k = 4; k < 8; k++) exp_q.push_back(mk(1, 0, 32'h200 + 4*k, 0));
    exp_q.push_back(mk(0, 0, 32'h4C, 0));
    bus.dREN = 1; bus.daddr = 32'h200; bus.iREN = 1; bus.iaddr = 32'h48;
    run_txns(10, 200, 1);
    chk("t3_iload", bus.iload, memword(32'h4C));
    tick(); tick();

    // T4a: three ERRORs abort; request withdrawn and address changed mid-busy
    script = '{ERROR, ERROR, ERROR};
    exp_q.push_back(mk(1, 0, 32'h300, 0));
    e0 = err_pulses;
    bus.dREN = 1; bus.daddr = 32'h300;
    tick();
    chk("t4_ramREN", bus.ramREN, 1);
    bus.dREN = 0; bus.daddr = 32'h999;
    lat = 0;
    while (bus.dwait && lat < 20) begin tick(); lat++; end
    chk("t4_abort_cycles", lat, 3);
    chk("t4_dload_abort", bus.dload, 32'hBAD0BAD0);
    chk("t4_ram_err", bus.ram_err, 1);
    tick();
    chk("t4_dwait_one_cycle", bus.dwait, 1);
    chk("t4_ram_err_pulse", bus.ram_err, 0);
    chk("t4_err_count", err_pulses - e0, 1);
    tick();

    // T4b: two ERRORs then ACCESS completes normally
    script = '{ERROR, ERROR, ACCESS};
    exp_q.push_back(mk(1, 0, 32'h304, 0));
    bus.dREN = 1; bus.daddr = 32'h304;
    run_txns(1, 20, 0);
    chk("t4_no_new_err", err_pulses - e0, 1);
    chk("t4_dload_ok", bus.dload, memword(32'h304));
    tick(); tick();

    // T5: reset during BUSY_D, then the held request is served again
    script = '{BUSY, BUSY, BUSY, ACCESS};
    exp_q.push_back(mk(1, 0, 32'h400, 0));
    bus.dREN = 1; bus.daddr = 32'h400;
    tick(); tick();
    chk("t5_busy", bus.ramREN, 1);
    nrst = 0;
    tick();
    chk("t5_rst_ramREN", bus.ramREN, 0);
    chk("t5_rst_ramWEN", bus.ramWEN, 0);
    chk("t5_rst_dload", bus.dload, 0);
    chk("t5_rst_dwait", bus.dwait, 1);
    exp_q.push_back(mk(1, 0, 32'h400, 0));
    nrst = 1;
    run_txns(1, 30, 0);
    chk("t5_dload", bus.dload, memword(32'h400));
    tick(); tick();

`ifdef MEM_RESP_STATS_EN
    // T6: counters from a fresh reset: 2 fetches + 1 data, 2 busy cycles each
    nrst = 0;
    tick();
    chk("t6_rst_icount", stat_icount, 0);
    chk("t6_rst_dcount", stat_dcount, 0);
    chk("t6_rst_stall", stat_stall, 0);
    nrst = 1;
    script = '{BUSY, ACCESS};
    exp_q.push_back(mk(0, 0, 32'h80, 0));
    exp_q.push_back(mk(0, 0, 32'h84, 0));
    bus.iREN = 1; bus.iaddr = 32'h80;
    run_txns(2, 30, 1);
    exp_q.push_back(mk(1, 0, 32'h500, 0));
    bus.dREN = 1; bus.daddr = 32'h500;
    run_txns(1, 30, 0);
    tick(); tick();
    chk("t6_icount", stat_icount, 2);
    chk("t6_dcount", stat_dcount, 1);
    chk("t6_stall", stat_stall, 6);
`endif

    tick();
    chk("end_queue_empty", exp_q.size(), 0);
    chk("end_in_txn", in_txn, 0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
